// File: rtl/zerosoc_pad_pkg.sv
// Shared types and constants for the zerosoc pad-ring controller.
package zerosoc_pad_pkg;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SRC_W     = 6;
  localparam int unsigned CFG_W     = 8;
  localparam int unsigned PAD_REG_W = 17;

  // Field order matches the register layout: SRC[5:0] ALT[6] IE[7] CFG[15:8] DEB_EN[16].
  typedef struct packed {
    logic             deb_en;
    logic [CFG_W-1:0] cfg;
    logic             ie;
    logic             alt;
    logic [SRC_W-1:0] src;
  } pad_reg_t;

  // The debounce-threshold register sits right after the last pad register.
  function automatic logic [ADDR_W-1:0] deb_thr_addr(int unsigned npads);
    return ADDR_W'(npads);
  endfunction

  function automatic pad_reg_t pad_reg_reset(int unsigned p, int unsigned ngpio);
    pad_reg_t r;
    r     = '0;
    r.src = SRC_W'(p % ngpio);
    r.ie  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pad_ctrl_filter.sv
// Per-pad input conditioning: synchroniser chain followed by an optional debounce filter.
module pad_ctrl_filter #(
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned DEB_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             deb_en,
  input  logic             ie,
  input  logic [DEB_W-1:0] thr,
  output logic             value_c
);

  logic [SYNC_STG-1:0] sync_q;
  logic                sync_last_q;
  logic                filt_q;
  logic [DEB_W-1:0]    cnt_q;
  logic [DEB_W-1:0]    cnt_c;
  logic                sync;

  assign sync = sync_q[SYNC_STG-1];

  // cnt_c = cycles the current sync value has been held, minus one (saturating).
  always_comb begin
    cnt_c = '0;
    if (sync == sync_last_q) begin
      cnt_c = (&cnt_q) ? cnt_q : cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_last_q <= 1'b0;
      cnt_q       <= '0;
      filt_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STG-2:0], din};
      sync_last_q <= sync;
      if (!deb_en) begin
        cnt_q  <= '0;
        filt_q <= sync;
      end else begin
        cnt_q <= cnt_c;
        if (cnt_c >= thr) filt_q <= sync;
      end
    end
  end

  assign value_c = ie & (deb_en ? filt_q : sync);

endmodule

// File: rtl/zerosoc_pad_ctrl.sv
// Pad-ring glue: per-pad register file, output mux, filtered input routing to GPIO/alt functions.
module zerosoc_pad_ctrl
  import zerosoc_pad_pkg::*;
#(
  parameter int unsigned NPADS    = 36,
  parameter int unsigned NGPIO    = 32,
  parameter int unsigned NALT     = 4,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned DEB_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                reg_req_i,
  input  logic                reg_we_i,
  input  logic [ADDR_W-1:0]   reg_addr_i,
  input  logic [DATA_W-1:0]   reg_wdata_i,
  output logic [DATA_W-1:0]   reg_rdata_o,
  output logic                reg_ack_o,
  input  logic [NGPIO-1:0]    gpio_o_i,
  input  logic [NGPIO-1:0]    gpio_en_i,
  output logic [NGPIO-1:0]    gpio_i_o,
  input  logic [NALT-1:0]     alt_o_i,
  input  logic [NALT-1:0]     alt_en_i,
  output logic [NALT-1:0]     alt_i_o,
  input  logic [NPADS-1:0]    pad_din_i,
  output logic [NPADS-1:0]    pad_dout_o,
  output logic [NPADS-1:0]    pad_oen_o,
  output logic [NPADS-1:0]    pad_ie_o,
  output logic [8*NPADS-1:0]  pad_cfg_o
);

  localparam logic [ADDR_W-1:0] THR_ADDR = deb_thr_addr(NPADS);

  pad_reg_t          pad_regs [NPADS];
  logic [DEB_W-1:0]  deb_thr;
  logic [DATA_W-1:0] rdata_c;
  logic [NPADS-1:0]  filt_c;
  logic [NGPIO-1:0]  gpio_in_c;
  logic [NALT-1:0]   alt_in_c;
  logic              unused_wdata;

  assign unused_wdata = ^reg_wdata_i[DATA_W-1:PAD_REG_W];

  // Register read decode; unmapped addresses read as zero.
  always_comb begin
    rdata_c = '0;
    for (int unsigned p = 0; p < NPADS; p++) begin
      if (reg_addr_i == ADDR_W'(p)) rdata_c = DATA_W'(pad_regs[p]);
    end
    if (reg_addr_i == THR_ADDR) rdata_c = DATA_W'(deb_thr);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NPADS; p++) pad_regs[p] <= pad_reg_reset(p, NGPIO);
      deb_thr     <= '0;
      reg_ack_o   <= 1'b0;
      reg_rdata_o <= '0;
    end else begin
      reg_ack_o   <= reg_req_i;
      reg_rdata_o <= '0;
      if (reg_req_i) begin
        if (reg_we_i) begin
          for (int unsigned p = 0; p < NPADS; p++) begin
            if (reg_addr_i == ADDR_W'(p)) pad_regs[p] <= pad_reg_t'(reg_wdata_i[PAD_REG_W-1:0]);
          end
          if (reg_addr_i == THR_ADDR) deb_thr <= reg_wdata_i[DEB_W-1:0];
        end else begin
          reg_rdata_o <= rdata_c;
        end
      end
    end
  end

  // Output mux; an unmapped GPIO source leaves the pad driving 0 with its driver off.
  always_comb begin
    pad_dout_o = '0;
    pad_oen_o  = '1;
    pad_ie_o   = '0;
    pad_cfg_o  = '0;
    for (int unsigned p = 0; p < NPADS; p++) begin
      pad_ie_o[p]                  = pad_regs[p].ie;
      pad_cfg_o[CFG_W*p +: CFG_W]  = pad_regs[p].cfg;
      if (pad_regs[p].alt) begin
        for (int unsigned k = 0; k < NALT; k++) begin
          if ((32'(pad_regs[p].src) % NALT) == k) begin
            pad_dout_o[p] = alt_o_i[k];
            pad_oen_o[p]  = ~alt_en_i[k];
          end
        end
      end else begin
        for (int unsigned g = 0; g < NGPIO; g++) begin
          if (pad_regs[p].src == SRC_W'(g)) begin
            pad_dout_o[p] = gpio_o_i[g];
            pad_oen_o[p]  = ~gpio_en_i[g];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NPADS; p++) begin : g_pad
    pad_ctrl_filter #(
      .SYNC_STG (SYNC_STG),
      .DEB_W    (DEB_W)
    ) u_filter (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .din     (pad_din_i[p]),
      .deb_en  (pad_regs[p].deb_en),
      .ie      (pad_regs[p].ie),
      .thr     (deb_thr),
      .value_c (filt_c[p])
    );
  end

  // Walk pads high to low so the lowest-index matching pad wins.
  always_comb begin
    gpio_in_c = '0;
    alt_in_c  = '0;
    for (int p = int'(NPADS) - 1; p >= 0; p--) begin
      if (pad_regs[p].ie) begin
        if (!pad_regs[p].alt) begin
          for (int unsigned g = 0; g < NGPIO; g++) begin
            if (pad_regs[p].src == SRC_W'(g)) gpio_in_c[g] = filt_c[p];
          end
        end else begin
          for (int unsigned k = 0; k < NALT; k++) begin
            if ((32'(pad_regs[p].src) % NALT) == k) alt_in_c[k] = filt_c[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gpio_i_o <= '0;
      alt_i_o  <= '0;
    end else begin
      gpio_i_o <= gpio_in_c;
      alt_i_o  <= alt_in_c;
    end
  end

endmodule
